// File: rtl/stereo_arb_pkg.sv
// Shared types for the stereo frame-pair capture arbiter.
package stereo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      HOLD = 2'd2
   } top_state_e;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ACTIVE   = 2'd1,
      DONE     = 2'd2
   } trk_state_e;

   localparam logic CAM_L = 1'b0;
   localparam logic CAM_R = 1'b1;

endpackage

// File: rtl/cam_frame_tracker.sv
// Per-camera frame position tracker: decides whether the current word lies inside the frame.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   WAIT_SOF | frame not started; only a word carrying sof is writable
//   ACTIVE   | inside the frame; every word is writable
//   DONE     | eof word accepted; further words are discarded
module cam_frame_tracker
   import stereo_arb_pkg::*;
(
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       sof,
   input  logic       eof,
   output trk_state_e state,
   output logic       writable
);

   trk_state_e state_q, state_d;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state_q <= WAIT_SOF;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = WAIT_SOF;
      end else begin
         case (state_q)
            WAIT_SOF: if (sof) state_d = ACTIVE;
            ACTIVE:   if (eof) state_d = DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   assign state    = state_q;
   assign writable = (state_q == ACTIVE) || ((state_q == WAIT_SOF) && sof);

endmodule

// File: rtl/stereo_wr_arbiter.sv
// Sequences one stereo snapshot and round-robins the left/right capture streams onto one RAM write port.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no snapshot in progress; all words discarded
//   CAPT  | capturing; trackers gate writes, timeout counter running
//   HOLD  | complete pair stored; RAM stable until pair_ack
module stereo_wr_arbiter
   import stereo_arb_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 3,
   parameter int TIMEOUT = 2000000
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              l_sof,
   input  logic              l_eof,
   input  logic              l_valid,
   output logic              l_ready,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_data,
   input  logic              r_sof,
   input  logic              r_eof,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic [ADDR_W:0]   wraddress,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   output logic              pair_ready,
   input  logic              pair_ack,
   output logic              busy,
   output logic              timeout_err
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   top_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tmo_q, tmo_d;
   logic              last_q;
   logic              wren_q;
   logic [ADDR_W:0]   wraddress_q;
   logic [DATA_W-1:0] data_q;

   trk_state_e l_state, r_state;
   logic       l_writable, r_writable;
   logic       in_capt, trk_clear, both_done;
   logic       l_req, r_req, gnt_l, gnt_r;

   assign in_capt   = (state_q == CAPT);
   assign trk_clear = (state_q == IDLE) && start;
   assign both_done = (l_state == DONE) && (r_state == DONE);

   // eof only closes the frame once its word (if any) is actually taken,
   // so a losing eof word is still written on a later cycle.
   cam_frame_tracker u_trk_l (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .clear    (trk_clear),
      .sof      (l_sof && in_capt),
      .eof      (l_eof && in_capt && (!l_valid || l_ready)),
      .state    (l_state),
      .writable (l_writable)
   );

   cam_frame_tracker u_trk_r (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .clear    (trk_clear),
      .sof      (r_sof && in_capt),
      .eof      (r_eof && in_capt && (!r_valid || r_ready)),
      .state    (r_state),
      .writable (r_writable)
   );

   assign l_req   = in_capt && l_writable && l_valid;
   assign r_req   = in_capt && r_writable && r_valid;
   assign gnt_l   = l_req && (!r_req || (last_q == CAM_R));
   assign gnt_r   = r_req && !gnt_l;
   assign l_ready = !l_req || gnt_l;
   assign r_ready = !r_req || gnt_r;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CAPT;
               cnt_d   = '0;
            end
         end
         CAPT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (both_done) begin
               state_d = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end
         end
         HOLD:    if (pair_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         wren_q      <= 1'b0;
         wraddress_q <= '0;
         data_q      <= '0;
         last_q      <= CAM_R;
      end else begin
         wren_q <= gnt_l || gnt_r;
         if (gnt_l) begin
            wraddress_q <= {CAM_L, l_addr};
            data_q      <= l_data;
            last_q      <= CAM_L;
         end else if (gnt_r) begin
            wraddress_q <= {CAM_R, r_addr};
            data_q      <= r_data;
            last_q      <= CAM_R;
         end
      end
   end

   assign wren        = wren_q;
   assign wraddress   = wraddress_q;
   assign data        = data_q;
   assign timeout_err = tmo_q;
   assign busy        = (state_q != IDLE);
   assign pair_ready  = (state_q == HOLD);

endmodule
